// File: rtl/vs_masked_correlator_argmax_pkg.sv
// Shared types and fixed-point helpers for the masked correlator / argmax engine.
// Helpers work on a wide signed container so one function serves every width.
package vs_masked_correlator_argmax_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, SCAN} state_t;

  localparam int FX_W = 128;
  typedef logic signed [FX_W-1:0] fx_t;

  // Clamp x to the signed range of a w-bit word.
  function automatic fx_t sat_w(input fx_t x, input int w);
    fx_t hi;
    fx_t lo;
    hi = (fx_t'(1) <<< (w - 1)) - fx_t'(1);
    lo = -hi - fx_t'(1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // |x| clamped to w bits, so the most negative value maps to the max positive.
  function automatic fx_t abs_sat(input fx_t x, input int w);
    return sat_w((x < 0) ? -x : x, w);
  endfunction

endpackage

// File: rtl/vs_sat_mac_lane.sv
// One MAC lane: full-width product, shift by Q, saturating accumulate in ACC_W,
// and a DW-saturated view of the accumulator.
module vs_sat_mac_lane
  import vs_masked_correlator_argmax_pkg::*;
#(
  parameter int DW    = 32,
  parameter int Q     = 15,
  parameter int ACC_W = 40
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sat_out
);

  logic signed [ACC_W-1:0]  acc;
  logic signed [2*DW-1:0]   prod;
  fx_t                      sum;

  always_comb begin
    // Low 2*DW bits of the sign-extended product are the exact signed product.
    prod = $signed({{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b});
    sum  = fx_t'(acc) + sat_w(fx_t'(prod >>> Q), ACC_W);
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear) acc <= '0;
    else if (en)           acc <= ACC_W'(sat_w(sum, ACC_W));
  end

  assign sat_out = DW'(sat_w(fx_t'(acc), DW));

endmodule

// File: rtl/vs_masked_correlator_argmax.sv
// Batched sensing-matrix / residual inner products with a fused masked
// max-|value| search; LANES columns are accumulated per batch then scanned.
module vs_masked_correlator_argmax
  import vs_masked_correlator_argmax_pkg::*;
#(
  parameter int ROWS      = 64,
  parameter int COLUMNS   = 256,
  parameter int LANES     = 16,
  parameter int DW        = 32,
  parameter int Q         = 15,
  parameter int GUARD     = 8,
  parameter int AUTO_MASK = 1
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   rd_en,
  output logic [$clog2(ROWS)-1:0]                res_addr,
  input  logic [DW-1:0]                          res_rdata,
  output logic [$clog2(ROWS*COLUMNS/LANES)-1:0]  phi_addr,
  input  logic [LANES*DW-1:0]                    phi_rdata,
  input  logic                                   mask_clear,
  input  logic                                   mask_set,
  input  logic [$clog2(COLUMNS)-1:0]             mask_index,
  output logic                                   prod_valid,
  output logic [$clog2(COLUMNS)-1:0]             prod_index,
  output logic [DW-1:0]                          prod_data,
  output logic [$clog2(COLUMNS)-1:0]             best_index,
  output logic [DW-1:0]                          best_value,
  output logic                                   found
);

  localparam int BATCHES = COLUMNS / LANES;
  localparam int ACC_W   = DW + GUARD;
  localparam int RAW     = $clog2(ROWS);
  localparam int CIW     = $clog2(COLUMNS);
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BW      = (BATCHES > 1) ? $clog2(BATCHES) : 1;

  state_t                   state, state_nxt;
  logic [LW-1:0]            lane;
  logic [BW-1:0]            batch;
  logic [CIW-1:0]           col;
  logic [COLUMNS-1:0]       mask;
  logic                     mac_en;
  logic [LANES-1:0][DW-1:0] lane_out;
  logic                     row_last, lane_last, batch_last;
  logic                     accept, acc_clear, finish, take;
  logic [DW-1:0]            cand_abs;
  logic [CIW-1:0]           win_index;

  assign row_last   = (res_addr == RAW'(ROWS - 1));
  assign lane_last  = (lane == LW'(LANES - 1));
  assign batch_last = (batch == BW'(BATCHES - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vs_sat_mac_lane #(.DW(DW), .Q(Q), .ACC_W(ACC_W)) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (acc_clear),
      .en      (mac_en),
      .a       (res_rdata),
      .b       (phi_rdata[l*DW +: DW]),
      .sat_out (lane_out[l])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    acc_clear = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE:  if (start) begin
               accept    = 1'b1;
               acc_clear = 1'b1;
               state_nxt = ACCUM;
             end
      ACCUM: if (row_last) state_nxt = DRAIN;
      DRAIN: state_nxt = SCAN;
      SCAN:  if (lane_last) begin
               if (batch_last) begin
                 finish    = 1'b1;
                 state_nxt = IDLE;
               end else begin
                 acc_clear = 1'b1;
                 state_nxt = ACCUM;
               end
             end
      default: state_nxt = IDLE;
    endcase
    // Strict '>' keeps the earlier (lower) column on ties.
    cand_abs  = DW'(abs_sat(fx_t'($signed(lane_out[lane])), DW));
    take      = (state == SCAN) && !mask[col] && (!found || cand_abs > best_value);
    win_index = take ? col : best_index;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      mac_en     <= 1'b0;
      res_addr   <= '0;
      phi_addr   <= '0;
      lane       <= '0;
      batch      <= '0;
      col        <= '0;
      mask       <= '0;
      prod_valid <= 1'b0;
      prod_index <= '0;
      prod_data  <= '0;
      best_index <= '0;
      best_value <= '0;
      found      <= 1'b0;
    end else begin
      done       <= finish;
      busy       <= (state_nxt != IDLE);
      mac_en     <= rd_en;
      prod_valid <= (state == SCAN);
      if (state == SCAN) begin
        prod_index <= col;
        prod_data  <= lane_out[lane];
      end
      case (state)
        IDLE: if (accept) begin
          rd_en      <= 1'b1;
          res_addr   <= '0;
          phi_addr   <= '0;
          batch      <= '0;
          col        <= '0;
          found      <= 1'b0;
          best_index <= '0;
          best_value <= '0;
        end
        ACCUM: begin
          lane <= '0;
          if (row_last) rd_en <= 1'b0;
          else begin
            res_addr <= res_addr + 1'b1;
            phi_addr <= phi_addr + 1'b1;
          end
        end
        SCAN: begin
          col  <= col + 1'b1;
          lane <= lane_last ? '0 : lane + 1'b1;
          if (take) begin
            found      <= 1'b1;
            best_index <= col;
            best_value <= cand_abs;
          end
          // Batch rows are contiguous, so the next batch starts one past the last row.
          if (lane_last && !batch_last) begin
            batch    <= batch + 1'b1;
            rd_en    <= 1'b1;
            res_addr <= '0;
            phi_addr <= phi_addr + 1'b1;
          end
        end
        default: ;
      endcase
      if (state == IDLE) begin
        if (mask_clear) mask <= '0;
        if (mask_set)   mask[mask_index] <= 1'b1;
      end
      if (finish && AUTO_MASK != 0 && (take || found)) mask[win_index] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vs_masked_correlator_argmax.sv
// Bench for vs_masked_correlator_argmax: directed vector table, randomized runs
// against a plain-arithmetic reference, mid-run reset and busy-ignore sequences.
module tb_vs_masked_correlator_argmax;

  localparam int ROWS = 4, COLUMNS = 8, LANES = 4, DW = 32, Q = 15, GUARD = 8, AUTO_MASK = 1;
  localparam int BATCHES  = COLUMNS / LANES;
  localparam int ACC_W    = DW + GUARD;
  localparam int DONE_CYC = BATCHES * (ROWS + LANES + 1) + 1;
  localparam int MAXI     = 32'h7FFFFFFF;
  localparam int MINI     = 32'h80000000;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic                mask_clear = 1'b0;
  logic                mask_set = 1'b0;
  logic [2:0]          mask_index = 3'd0;
  logic                busy, done, rd_en, prod_valid, found;
  logic [1:0]          res_addr;
  logic [2:0]          phi_addr, prod_index, best_index;
  logic [DW-1:0]       res_rdata, prod_data, best_value;
  logic [LANES*DW-1:0] phi_rdata;

  vs_masked_correlator_argmax #(
    .ROWS(ROWS), .COLUMNS(COLUMNS), .LANES(LANES), .DW(DW), .Q(Q),
    .GUARD(GUARD), .AUTO_MASK(AUTO_MASK)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .res_addr(res_addr), .res_rdata(res_rdata), .phi_addr(phi_addr),
    .phi_rdata(phi_rdata), .mask_clear(mask_clear), .mask_set(mask_set),
    .mask_index(mask_index), .prod_valid(prod_valid), .prod_index(prod_index),
    .prod_data(prod_data), .best_index(best_index), .best_value(best_value), .found(found)
  );

  always #5 clock = ~clock;

  int     res_mem [ROWS];
  int     col_mem [COLUMNS][ROWS];
  bit     model_mask [COLUMNS];
  longint exp_p [COLUMNS];
  longint got_p [COLUMNS];
  bit     exp_found;
  int     exp_idx;
  longint exp_val;
  int     n_pass = 0, n_total = 0;

  // External RAMs with one cycle of read latency.
  always @(posedge clock) begin
    res_rdata <= res_mem[res_addr];
    for (int l = 0; l < LANES; l++)
      phi_rdata[l*DW +: DW] <= col_mem[(int'(phi_addr) / ROWS) * LANES + l][int'(phi_addr) % ROWS];
  end

  task automatic check(input string tag, input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d", tag, name, act, exp);
  endtask

  function automatic longint sat(input longint x, input int w);
    longint hi;
    hi = (longint'(1) <<< (w - 1)) - 1;
    if (x > hi) return hi;
    if (x < -hi - 1) return -hi - 1;
    return x;
  endfunction

  // Reference: every inner product by direct summation, then masked argmax over |value|.
  task automatic model_run();
    longint acc, p, a;
    exp_found = 0; exp_idx = 0; exp_val = 0;
    for (int c = 0; c < COLUMNS; c++) begin
      acc = 0;
      for (int r = 0; r < ROWS; r++) begin
        p   = (longint'(res_mem[r]) * longint'(col_mem[c][r])) >>> Q;
        acc = sat(acc + sat(p, ACC_W), ACC_W);
      end
      exp_p[c] = sat(acc, DW);
      if (!model_mask[c]) begin
        a = sat((exp_p[c] < 0) ? -exp_p[c] : exp_p[c], DW);
        if (!exp_found || a > exp_val) begin
          exp_found = 1; exp_idx = c; exp_val = a;
        end
      end
    end
    if (AUTO_MASK != 0 && exp_found) model_mask[exp_idx] = 1;
  endtask

  task automatic mask_cmd(input bit clr, input bit set, input int idx);
    mask_clear = clr; mask_set = set; mask_index = 3'(idx);
    @(posedge clock); #1;
    mask_clear = 0; mask_set = 0;
    if (clr) for (int c = 0; c < COLUMNS; c++) model_mask[c] = 0;
    if (set) model_mask[idx] = 1;
  endtask

  // One full run from start; poke_cyc drives start+mask commands mid-run (must be ignored).
  task automatic do_run(input string tag, input int poke_cyc = -1);
    int     cyc, nrd;
    bit     got_done;
    int     pidx[$];
    longint pdat[$];
    model_run();
    for (int c = 0; c < COLUMNS; c++) got_p[c] = 64'h5A5A;
    start = 1; @(posedge clock); #1; start = 0; cyc = 1;
    check(tag, "busy_rise", busy, 1);
    got_done = 0; nrd = 0;
    while (!got_done && cyc < 200) begin
      if (prod_valid) begin
        pidx.push_back(int'(prod_index));
        pdat.push_back(longint'($signed(prod_data)));
      end
      if (rd_en) nrd++;
      if (done) got_done = 1;
      else begin
        if (cyc == poke_cyc) begin
          start = 1; mask_clear = 1; mask_set = 1; mask_index = 3'd5;
        end else if (cyc == poke_cyc + 1) begin
          start = 0; mask_clear = 0; mask_set = 0;
        end
        @(posedge clock); #1; cyc++;
      end
    end
    start = 0; mask_clear = 0; mask_set = 0;
    check(tag, "done_seen", got_done, 1);
    check(tag, "done_cycle", cyc, DONE_CYC);
    check(tag, "busy_at_done", busy, 0);
    check(tag, "rd_en_count", nrd, ROWS * BATCHES);
    check(tag, "prod_count", pidx.size(), COLUMNS);
    for (int k = 0; k < pidx.size() && k < COLUMNS; k++) begin
      check(tag, $sformatf("prod_index%0d", k), pidx[k], k);
      check(tag, $sformatf("prod_data%0d", k), pdat[k], exp_p[k]);
      if (pidx[k] < COLUMNS) got_p[pidx[k]] = pdat[k];
    end
    check(tag, "found", found, exp_found);
    check(tag, "best_index", best_index, exp_idx);
    check(tag, "best_value", best_value, exp_val);
    @(posedge clock); #1;
    check(tag, "done_pulse", done, 0);
  endtask

  function automatic int rnd(input int mode);
    case (mode)
      0:       return int'($urandom_range(0, 65535)) - 32768;
      1:       return int'($urandom());
      default: return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1 << 20)) - (1 << 19) : 0;
    endcase
  endfunction

  typedef struct {
    int     res_v, other_v, c2_v, c5_v;
    bit     pre_clear, mask_all;
    bit     exp_found;
    int     exp_idx;
    longint exp_val, exp_p2, exp_p5;
  } vec_t;

  vec_t vecs [7];

  task automatic load(input int rv, input int ov, input int c2, input int c5);
    for (int r = 0; r < ROWS; r++) begin
      res_mem[r] = rv;
      for (int c = 0; c < COLUMNS; c++) col_mem[c][r] = (c == 2) ? c2 : (c == 5) ? c5 : ov;
    end
  endtask

  initial begin
    int   cyc;
    bit   saw_done;
    vecs[0] = '{16384, 0, 0,      16384, 1, 0, 1, 5, 32768, 0, 32768};
    vecs[1] = '{16384, 0, -16384, 16384, 1, 0, 1, 2, 32768, -32768, 32768};
    vecs[2] = '{16384, 0, 0,      16384, 1, 0, 1, 5, 32768, 0, 32768};
    vecs[3] = '{16384, 0, 0,      16384, 0, 0, 1, 0, 0, 0, 32768};
    vecs[4] = '{16384, 0, 0,      16384, 1, 1, 0, 0, 0, 0, 32768};
    vecs[5] = '{MAXI, MAXI, MAXI, MAXI, 1, 0, 1, 0, MAXI, MAXI, MAXI};
    vecs[6] = '{MINI, MAXI, MAXI, MAXI, 1, 0, 1, 0, MAXI, MINI, MINI};
    load(0, 0, 0, 0);
    for (int c = 0; c < COLUMNS; c++) model_mask[c] = 0;

    repeat (3) @(posedge clock);
    #1;
    check("reset", "flags", {busy, done, rd_en, prod_valid, found}, 0);
    check("reset", "addrs", {res_addr, phi_addr, prod_index, best_index}, 0);
    check("reset", "data", {prod_data, best_value}, 0);
    reset_n = 1;
    @(posedge clock); #1;
    check("idle", "flags", {busy, done, rd_en, prod_valid, found}, 0);

    for (int i = 0; i < 7; i++) begin
      load(vecs[i].res_v, vecs[i].other_v, vecs[i].c2_v, vecs[i].c5_v);
      if (vecs[i].pre_clear) mask_cmd(1, 0, 0);
      if (vecs[i].mask_all) for (int c = 0; c < COLUMNS; c++) mask_cmd(0, 1, c);
      do_run($sformatf("vec%0d", i));
      check($sformatf("vec%0d", i), "tbl_found", found, vecs[i].exp_found);
      check($sformatf("vec%0d", i), "tbl_index", best_index, vecs[i].exp_idx);
      check($sformatf("vec%0d", i), "tbl_value", best_value, vecs[i].exp_val);
      check($sformatf("vec%0d", i), "tbl_prod2", got_p[2], vecs[i].exp_p2);
      check($sformatf("vec%0d", i), "tbl_prod5", got_p[5], vecs[i].exp_p5);
    end

    // Start and mask commands while busy: column 5 must still win.
    load(16384, 0, 0, 16384);
    mask_cmd(1, 0, 0);
    do_run("busy_ignore", 3);
    check("busy_ignore", "tbl_index", best_index, 5);

    // Mid-run reset: no done, outputs cleared, mask cleared, clean rerun.
    mask_cmd(1, 0, 0);
    mask_cmd(0, 1, 5);
    start = 1; @(posedge clock); #1; start = 0; cyc = 1; saw_done = 0;
    while (cyc < 7) begin
      if (done) saw_done = 1;
      @(posedge clock); #1; cyc++;
    end
    reset_n = 0;
    @(posedge clock); #1;
    reset_n = 1;
    check("abort", "no_done", saw_done | done, 0);
    check("abort", "busy", busy, 0);
    check("abort", "rd_en", rd_en, 0);
    check("abort", "prod_valid", prod_valid, 0);
    for (int c = 0; c < COLUMNS; c++) model_mask[c] = 0;
    do_run("after_reset");
    check("after_reset", "tbl_index", best_index, 5);

    for (int t = 0; t < 12; t++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int r = 0; r < ROWS; r++) begin
        res_mem[r] = rnd(mode);
        for (int c = 0; c < COLUMNS; c++) col_mem[c][r] = rnd(mode);
      end
      if ($urandom_range(0, 1) == 1) mask_cmd(1, 0, 0);
      repeat ($urandom_range(0, 3))
        mask_cmd($urandom_range(0, 3) == 0, 1, int'($urandom_range(0, COLUMNS - 1)));
      do_run($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
